// File: rtl/sram_1rw1r_arbiter_if.sv
// Client-side bundle for one SRAM requester: command, combinational grant, tagged read return.
// Grant is combinational in the request cycle; read data returns two cycles after the grant.
// No backpressure on the return path: the client must accept every rvalid pulse.
interface sram_1rw1r_arbiter_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_WMASKS = 4
);
    logic                  req;
    logic                  we;
    logic [NUM_WMASKS-1:0] wmask;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  gnt;
    logic                  rvalid;
    logic [DATA_WIDTH-1:0] rdata;

    modport master (output req, we, wmask, addr, wdata, input  gnt, rvalid, rdata);
    modport slave  (input  req, we, wmask, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/sram_1rw1r_arbiter.sv
// Shares one 1RW+1R SRAM: m0/m1 round-robin on RW port 0, read-only m2 on R port 1.
// Grants are combinational; read data returns with rvalid exactly 2 cycles after the grant.
// Requesters hold req until gnt; responses cannot be stalled.
module sram_1rw1r_arbiter #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_WMASKS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    sram_1rw1r_arbiter_if.slave   m0,
    sram_1rw1r_arbiter_if.slave   m1,
    sram_1rw1r_arbiter_if.slave   m2,
    output logic                  sram_clk0,
    output logic                  sram_csb0,
    output logic                  sram_web0,
    output logic [NUM_WMASKS-1:0] sram_wmask0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    input  logic [DATA_WIDTH-1:0] sram_dout0,
    output logic                  sram_clk1,
    output logic                  sram_csb1,
    output logic [ADDR_WIDTH-1:0] sram_addr1,
    input  logic [DATA_WIDTH-1:0] sram_dout1
);

    typedef struct packed {
        logic                  we;
        logic [NUM_WMASKS-1:0] wmask;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } p0_cmd_t;

    typedef struct packed {
        logic p0_vld;
        logic p0_id;
        logic p2_vld;
    } rd_tag_t;

    logic    rr_ptr;
    logic    gnt0;
    logic    gnt1;
    logic    gnt2;
    logic    p0_gnt;
    logic    collide;
    p0_cmd_t cmd_m0;
    p0_cmd_t cmd_m1;
    p0_cmd_t win_cmd;
    rd_tag_t tag_d;
    rd_tag_t tag_q;

    logic                  m0_rvalid_q;
    logic                  m1_rvalid_q;
    logic                  m2_rvalid_q;
    logic [DATA_WIDTH-1:0] m0_rdata_q;
    logic [DATA_WIDTH-1:0] m1_rdata_q;
    logic [DATA_WIDTH-1:0] m2_rdata_q;

    // m2 is read-only; its write fields exist only because the bundle is shared.
    wire unused_m2 = ^{m2.we, m2.wmask, m2.wdata};

    assign sram_clk0 = clk;
    assign sram_clk1 = clk;

    assign cmd_m0 = {m0.we, m0.wmask, m0.addr, m0.wdata};
    assign cmd_m1 = {m1.we, m1.wmask, m1.addr, m1.wdata};

    // rr_ptr names the master that wins a tie; it points at whoever lost last time.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst_n) begin
            if (m0.req && m1.req) begin
                gnt0 = !rr_ptr;
                gnt1 = rr_ptr;
            end else begin
                gnt0 = m0.req;
                gnt1 = m1.req;
            end
        end
    end

    assign p0_gnt = gnt0 | gnt1;

    always_comb begin
        win_cmd = '0;
        if (gnt0) begin
            win_cmd = cmd_m0;
        end else if (gnt1) begin
            win_cmd = cmd_m1;
        end
    end

    // A same-cycle port-0 write to the address m2 wants would race the port-1 read; m2 retries.
    assign collide = p0_gnt && win_cmd.we && (win_cmd.addr == m2.addr);
    assign gnt2    = rst_n && m2.req && !collide;

    assign m0.gnt = gnt0;
    assign m1.gnt = gnt1;
    assign m2.gnt = gnt2;

    assign sram_csb0   = !p0_gnt;
    assign sram_web0   = !win_cmd.we;
    assign sram_wmask0 = win_cmd.wmask;
    assign sram_addr0  = win_cmd.addr;
    assign sram_din0   = win_cmd.wdata;

    assign sram_csb1  = !gnt2;
    assign sram_addr1 = gnt2 ? m2.addr : '0;

    assign tag_d = '{p0_vld: p0_gnt && !win_cmd.we, p0_id: gnt1, p2_vld: gnt2};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr <= 1'b0;
            tag_q  <= '0;
        end else begin
            if (p0_gnt) begin
                rr_ptr <= gnt0;
            end
            tag_q <= tag_d;
        end
    end

    // The SRAM drives dout during the cycle after the grant; capture it as the tag retires.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            m0_rvalid_q <= 1'b0;
            m1_rvalid_q <= 1'b0;
            m2_rvalid_q <= 1'b0;
            m0_rdata_q  <= '0;
            m1_rdata_q  <= '0;
            m2_rdata_q  <= '0;
        end else begin
            m0_rvalid_q <= tag_q.p0_vld && !tag_q.p0_id;
            m1_rvalid_q <= tag_q.p0_vld && tag_q.p0_id;
            m2_rvalid_q <= tag_q.p2_vld;
            if (tag_q.p0_vld && !tag_q.p0_id) begin
                m0_rdata_q <= sram_dout0;
            end
            if (tag_q.p0_vld && tag_q.p0_id) begin
                m1_rdata_q <= sram_dout0;
            end
            if (tag_q.p2_vld) begin
                m2_rdata_q <= sram_dout1;
            end
        end
    end

    assign m0.rvalid = m0_rvalid_q;
    assign m1.rvalid = m1_rvalid_q;
    assign m2.rvalid = m2_rvalid_q;
    assign m0.rdata  = m0_rdata_q;
    assign m1.rdata  = m1_rdata_q;
    assign m2.rdata  = m2_rdata_q;

endmodule
